// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and command constants for the PS/2 host side.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

   // Host transmitter sequencing states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      START     = 3'd2,
      SEND      = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5
   } state_e;

   // Common keyboard commands and the device acknowledge byte
   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0] PS2_ACK          = 8'hFA;

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_sync
// Description : Two-flop synchronizers for PS2_CLK / PS2_DAT plus a
//               falling-edge strobe on the synchronized clock line.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_sync
   import ps2_pkg::*;
(
   input  logic clk,
   input  logic resetn,
   input  logic ps2_clk_i,
   input  logic ps2_dat_i,
   output logic clk_sync_o,
   output logic dat_sync_o,
   output logic clk_fall_o
);

   logic [1:0] clk_ff_q;
   logic [1:0] dat_ff_q;
   logic       clk_prev_q;

   // Resynchronize both lines; reset to the idle (pulled-up) level so no
   // spurious edge is seen after reset is released.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clk_ff_q   <= 2'b11;
         dat_ff_q   <= 2'b11;
         clk_prev_q <= 1'b1;
      end else begin
         clk_ff_q   <= {clk_ff_q[0], ps2_clk_i};
         dat_ff_q   <= {dat_ff_q[0], ps2_dat_i};
         clk_prev_q <= clk_ff_q[1];
      end
   end

   assign clk_sync_o = clk_ff_q[1];
   assign dat_sync_o = dat_ff_q[1];
   assign clk_fall_o = clk_prev_q & ~clk_ff_q[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 command transmitter. Inhibits the bus,
//               issues a request-to-send, shifts one byte plus odd parity
//               out on device clock falls and reports ack, nack or timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int START_CYCLES   = 1000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   output logic       tx_active,
   output logic       done,
   output logic       error,
   inout  wire        PS2_CLK,
   inout  wire        PS2_DAT
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STA_LAST = CNT_W'(START_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [8:0]       shift_q,   shift_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic             dat_low_q, dat_low_d;
   logic             done_q,    done_d;
   logic             error_q,   error_d;

   logic             clk_sync;
   logic             dat_sync;
   logic             clk_fall;
   logic             timeout;

   ps2_line_sync u_sync (
      .clk        (clk),
      .resetn     (resetn),
      .ps2_clk_i  (PS2_CLK),
      .ps2_dat_i  (PS2_DAT),
      .clk_sync_o (clk_sync),
      .dat_sync_o (dat_sync),
      .clk_fall_o (clk_fall)
   );

   // The counter measures time spent in the current state; in the
   // device-clocked states hitting the last count aborts the transfer.
   assign timeout = (cnt_q == TMO_LAST);

   // State, shared counter, shift data and line-drive registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         dat_low_q <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         dat_low_q <= dat_low_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   // Next-state logic; done/error are registered so they coincide with the
   // first IDLE cycle, where cmd_ready is already high again.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      dat_low_d = dat_low_q;
      done_d    = 1'b0;
      error_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d     = '0;
            dat_low_d = 1'b0;
            if (cmd_valid) begin
               shift_d   = {~^cmd_data, cmd_data};
               bit_cnt_d = '0;
               state_d   = INHIBIT;
            end
         end
         INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               cnt_d     = '0;
               dat_low_d = 1'b1;          // start bit, held through START
               state_d   = START;
            end
         end
         START: begin
            if (cnt_q == STA_LAST) begin
               cnt_d   = '0;              // timeout runs from clock release
               state_d = SEND;
            end
         end
         SEND: begin
            if (timeout) begin
               cnt_d     = '0;
               dat_low_d = 1'b0;
               error_d   = 1'b1;
               state_d   = IDLE;
            end else if (clk_fall) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 4'd9) begin
                  cnt_d     = '0;
                  dat_low_d = 1'b0;       // stop bit: line released
                  state_d   = ACK;
               end else begin
                  dat_low_d = ~shift_q[bit_cnt_q];
               end
            end
         end
         ACK: begin
            if (timeout) begin
               cnt_d   = '0;
               error_d = 1'b1;
               state_d = IDLE;
            end else if (clk_fall) begin
               cnt_d = '0;
               if (!dat_sync) begin
                  state_d = WAIT_IDLE;
               end else begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (timeout) begin
               cnt_d   = '0;
               error_d = 1'b1;
               state_d = IDLE;
            end else if (clk_sync && dat_sync) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d     = '0;
            dat_low_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   assign cmd_ready = (state_q == IDLE);
   assign tx_active = (state_q != IDLE);
   assign done      = done_q;
   assign error     = error_q;

   // Open-drain drivers: only ever pull low, otherwise release
   assign PS2_CLK = ((state_q == INHIBIT) || (state_q == START)) ? 1'b0 : 1'bz;
   assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with a PS/2 device model
//               and result/frame scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

   localparam int INH  = 40;
   localparam int STA  = 8;
   localparam int TMO  = 1500;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready;
   logic       tx_active;
   logic       done;
   logic       error;
   wire        ps2_clk_w;
   wire        ps2_dat_w;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;

   pullup (ps2_clk_w);
   pullup (ps2_dat_w);
   assign ps2_clk_w = dev_clk_low ? 1'b0 : 1'bz;
   assign ps2_dat_w = dev_dat_low ? 1'b0 : 1'bz;

   int checks = 0;
   int errors = 0;

   logic [1:0] res_q[$];   // 2'b01 = done, 2'b10 = error
   logic [9:0] frm_q[$];   // {stop, parity, data}

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .START_CYCLES   (STA),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .cmd_valid (cmd_valid),
      .cmd_data  (cmd_data),
      .cmd_ready (cmd_ready),
      .tx_active (tx_active),
      .done      (done),
      .error     (error),
      .PS2_CLK   (ps2_clk_w),
      .PS2_DAT   (ps2_dat_w)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Result scoreboard: every done/error pulse must match the next expectation
   always @(negedge clk) begin
      if (resetn && (done || error)) begin
         if (res_q.size() == 0) check_eq("unexpected_result", {30'd0, error, done}, 32'd0);
         else                   check_eq("result", {30'd0, error, done}, {30'd0, res_q.pop_front()});
         check_eq("ready_with_pulse", cmd_ready, 1);
      end
   end

   task automatic send_cmd(input logic [7:0] d, input logic [1:0] res, input bit push_frame);
      int n = 0;
      while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
      cmd_valid = 1'b1;
      cmd_data  = d;
      if (res != 2'b00) res_q.push_back(res);
      if (push_frame)   frm_q.push_back({1'b1, ~^d, d});
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Device model: checks the request-to-send timing, then clocks the frame.
   task automatic device(input bit do_clock, input bit ack, input int rst_fall);
      int n = 0, n_inh = 0, n_sta = 0;
      logic [9:0] obs = '0;
      while (ps2_clk_w !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
      check_eq("inhibit_seen", ps2_clk_w, 0);
      if (ps2_clk_w !== 1'b0) return;
      while (ps2_clk_w === 1'b0 && ps2_dat_w === 1'b1 && n_inh < 4000) begin n_inh++; @(negedge clk); end
      while (ps2_clk_w === 1'b0 && ps2_dat_w === 1'b0 && n_sta < 4000) begin n_sta++; @(negedge clk); end
      check_eq("inhibit_len", n_inh, INH);
      check_eq("start_len", n_sta, STA);
      check_eq("start_bit", {ps2_clk_w, ps2_dat_w}, 2'b10);
      if (!do_clock) begin
         n = 0;
         while (!error && n < 2 * TMO) begin @(negedge clk); n++; end
         check_eq("timeout_len", n, TMO);
         return;
      end
      for (int k = 1; k <= 10; k++) begin
         repeat (HALF) @(negedge clk);
         dev_clk_low = 1'b1;
         if (k == rst_fall) begin
            repeat (4) @(negedge clk);
            check_eq("dat_driven_before_rst", ps2_dat_w, 0);
            resetn = 1'b0;
            #1;
            check_eq("rst_dat_released", ps2_dat_w, 1);
            dev_clk_low = 1'b0;
            #1;
            check_eq("rst_clk_released", ps2_clk_w, 1);
            @(negedge clk);
            resetn = 1'b1;
            @(negedge clk);
            check_eq("rst_ready", cmd_ready, 1);
            check_eq("rst_active", tx_active, 0);
            return;
         end
         repeat (HALF) @(negedge clk);
         dev_clk_low = 1'b0;
         obs[k-1] = ps2_dat_w;
      end
      repeat (HALF / 2) @(negedge clk);
      dev_dat_low = ack;
      repeat (HALF / 2) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (4) @(negedge clk);
      dev_dat_low = 1'b0;
      check_eq("frame_queue", frm_q.size(), 1);
      if (frm_q.size() > 0) check_eq("frame", obs, frm_q.pop_front());
   endtask

   task automatic wait_results();
      int n = 0;
      while (res_q.size() != 0 && n < 4000) begin @(negedge clk); n++; end
      check_eq("result_pending", res_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int extra;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check_eq("reset_ready", cmd_ready, 1);
      check_eq("reset_active", tx_active, 0);
      check_eq("reset_pulses", {done, error}, 2'b00);
      check_eq("reset_lines", {ps2_clk_w, ps2_dat_w}, 2'b11);

      // Enable command, acked
      fork
         send_cmd(8'hF4, 2'b01, 1'b1);
         device(1'b1, 1'b1, 0);
      join
      wait_results();

      // Set-LEDs command, acked
      fork
         send_cmd(8'hED, 2'b01, 1'b1);
         device(1'b1, 1'b1, 0);
      join
      wait_results();

      // Device nacks
      fork
         send_cmd(8'h01, 2'b10, 1'b1);
         device(1'b1, 1'b0, 0);
      join
      wait_results();
      @(negedge clk);
      check_eq("nack_idle", cmd_ready, 1);
      check_eq("nack_lines", {ps2_clk_w, ps2_dat_w}, 2'b11);

      // Device never clocks
      fork
         send_cmd(8'hFF, 2'b10, 1'b0);
         device(1'b0, 1'b0, 0);
      join
      wait_results();
      @(negedge clk);
      check_eq("timeout_lines", {ps2_clk_w, ps2_dat_w}, 2'b11);

      // Reset asserted at fall 5 (d4 of 0x01 is 0, so data is being driven)
      fork
         send_cmd(8'h01, 2'b00, 1'b0);
         device(1'b1, 1'b1, 5);
      join
      repeat (5) @(negedge clk);
      check_eq("post_rst_lines", {ps2_clk_w, ps2_dat_w}, 2'b11);

      // cmd_valid pulsed mid-frame must be ignored
      fork
         send_cmd(8'hF4, 2'b01, 1'b1);
         device(1'b1, 1'b1, 0);
         begin
            repeat (INH + STA + 6 * HALF) @(negedge clk);
            check_eq("busy_during_send", tx_active, 1);
            cmd_valid = 1'b1;
            cmd_data  = 8'h55;
            @(negedge clk);
            cmd_valid = 1'b0;
         end
      join
      wait_results();
      extra = 0;
      repeat (2 * INH) begin
         @(negedge clk);
         if (ps2_clk_w !== 1'b1 || tx_active !== 1'b0) extra = 1;
      end
      check_eq("no_second_frame", extra, 0);
      check_eq("frames_left", frm_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
